vector_control_sequencer: RTL and testbench

Registered, parametrised successor to the combinational opcode decoder. It accepts one opcode per valid/ready handshake and drives a registered control word to the execute stage. Scalar ops issue as a single beat. Vector (AES) ops issue as VEC_BEATS consecutive beats with a beat index, so narrower vector datapaths can process a 128-bit state over several cycles. It sits between instruction fetch and the execute/memory stages and supports downstream stall and pipeline flush.

---
 rtl/vector_control_sequencer_pkg.sv | 53 +++++
 rtl/vector_control_sequencer_if.sv | 30 +++
 rtl/vector_control_sequencer_decoder.sv | 59 +++++
 rtl/vector_control_sequencer.sv | 131 +++++++++++++
 tb/tb_vector_control_sequencer.sv | 184 ++++++++++++++++++
 5 files changed

// File: rtl/vector_control_sequencer_pkg.sv
// vector_ctrl_pkg: shared definitions for the vector control sequencer.
//   - opcode localparams (OP_NOP .. OP_INVSUBBYTES)
//   - ctrl_word_t: decoded control word, fields in control_signals order
//   - state_t: sequencer state enum
//   - is_vector_op(): opcode MSB marks a vector (multi-beat) op
// Optional build macro used by the sequencer: VECTOR_CONTROL_SEQUENCER_ILLEGAL_TRAP_EN.
package vector_ctrl_pkg;

  localparam int OPC_W = 5;
  localparam int ALU_W = 5;
  localparam int WBS_W = 2;

  localparam logic [OPC_W-1:0] OP_NOP           = 5'b00000;
  localparam logic [OPC_W-1:0] OP_STR           = 5'b00001;
  localparam logic [OPC_W-1:0] OP_LDR           = 5'b00010;
  localparam logic [OPC_W-1:0] OP_BNE           = 5'b00011;
  localparam logic [OPC_W-1:0] OP_ADD1          = 5'b00100;
  localparam logic [OPC_W-1:0] OP_ADD           = 5'b00101;
  localparam logic [OPC_W-1:0] OP_XOR           = 5'b00110;
  localparam logic [OPC_W-1:0] OP_MUL           = 5'b00111;
  localparam logic [OPC_W-1:0] OP_VSTR          = 5'b10001;
  localparam logic [OPC_W-1:0] OP_VLDR          = 5'b10010;
  localparam logic [OPC_W-1:0] OP_VXOR          = 5'b10011;
  localparam logic [OPC_W-1:0] OP_ADDROUNDKEY   = 5'b10100;
  localparam logic [OPC_W-1:0] OP_MIXCOLUMNS    = 5'b10101;
  localparam logic [OPC_W-1:0] OP_SHIFTROWS     = 5'b10110;
  localparam logic [OPC_W-1:0] OP_SUBBYTES      = 5'b10111;
  localparam logic [OPC_W-1:0] OP_KEYEXPAND     = 5'b11000;
  localparam logic [OPC_W-1:0] OP_VAND          = 5'b11001;
  localparam logic [OPC_W-1:0] OP_VOR           = 5'b11010;
  localparam logic [OPC_W-1:0] OP_INVMIXCOLUMNS = 5'b11100;
  localparam logic [OPC_W-1:0] OP_INVSHIFTROWS  = 5'b11101;
  localparam logic [OPC_W-1:0] OP_INVSUBBYTES   = 5'b11110;

  typedef struct packed {
    logic             load;
    logic             wre;
    logic             vector_wre;
    logic             wme_a;
    logic             wme_b;
    logic [WBS_W-1:0] wb_sel;
    logic [WBS_W-1:0] vwb_sel;
    logic [ALU_W-1:0] alu_op;
    logic [ALU_W-1:0] valu_op;
  } ctrl_word_t;

  typedef enum logic {IDLE, BUSY} state_t;

  function automatic logic is_vector_op(input logic [OPC_W-1:0] op);
    return op[OPC_W-1];
  endfunction

endpackage

// File: rtl/vector_control_sequencer_if.sv
// vector_control_sequencer_if: fetch-side handshake plus execute-side control bus.
//   master: drives instr_valid, opcode, stall, flush; observes the rest.
//   slave : the sequencer; drives instr_ready, ctrl_valid, control_signals,
//           beat_idx, last_beat, is_branch.
interface vector_control_sequencer_if #(
  parameter int OPCODE_W = 5,
  parameter int CTRL_W   = 19,
  parameter int BIDX_W   = 2
) ();
  logic                instr_valid;
  logic [OPCODE_W-1:0] opcode;
  logic                instr_ready;
  logic                stall;
  logic                flush;
  logic                ctrl_valid;
  logic [CTRL_W-1:0]   control_signals;
  logic [BIDX_W-1:0]   beat_idx;
  logic                last_beat;
  logic                is_branch;

  modport master (
    output instr_valid, opcode, stall, flush,
    input  instr_ready, ctrl_valid, control_signals, beat_idx, last_beat, is_branch
  );

  modport slave (
    input  instr_valid, opcode, stall, flush,
    output instr_ready, ctrl_valid, control_signals, beat_idx, last_beat, is_branch
  );
endinterface

// File: rtl/vector_control_sequencer_decoder.sv
// opcode_decoder: combinational opcode -> ctrl_word_t map.
//   opcode  in  : instruction opcode
//   ctrl    out : decoded control word (all zero for nop/undefined)
//   illegal out : opcode is not in the decode table
module opcode_decoder
  import vector_ctrl_pkg::*;
(
  input  logic [OPC_W-1:0] opcode,
  output ctrl_word_t       ctrl,
  output logic             illegal
);

  always_comb begin
    ctrl    = '0;
    illegal = 1'b0;
    case (opcode)
      OP_NOP: begin
        ctrl.alu_op = opcode;
      end
      OP_STR: begin
        ctrl.wme_a  = 1'b1;
        ctrl.alu_op = opcode;
      end
      OP_LDR: begin
        ctrl.load   = 1'b1;
        ctrl.wre    = 1'b1;
        ctrl.alu_op = opcode;
      end
      OP_BNE: begin
        ctrl.alu_op = opcode;
      end
      OP_ADD1, OP_ADD, OP_XOR, OP_MUL: begin
        ctrl.wre    = 1'b1;
        ctrl.wb_sel = WBS_W'(1);
        ctrl.alu_op = opcode;
      end
      OP_VSTR: begin
        ctrl.wme_b   = 1'b1;
        ctrl.valu_op = opcode;
      end
      OP_VLDR: begin
        ctrl.load       = 1'b1;
        ctrl.vector_wre = 1'b1;
        ctrl.valu_op    = opcode;
      end
      OP_VXOR, OP_ADDROUNDKEY, OP_MIXCOLUMNS, OP_SHIFTROWS, OP_SUBBYTES,
      OP_KEYEXPAND, OP_VAND, OP_VOR, OP_INVMIXCOLUMNS, OP_INVSHIFTROWS,
      OP_INVSUBBYTES: begin
        ctrl.vector_wre = 1'b1;
        ctrl.vwb_sel    = WBS_W'(1);
        ctrl.valu_op    = opcode;
      end
      default: begin
        illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/vector_control_sequencer.sv
// vector_control_sequencer: registered opcode sequencer feeding the execute stage.
//   clk, rst : clock, synchronous active-high reset
//   bus      : vector_control_sequencer_if.slave (handshake in, control word out)
//   illegal_op (only with VECTOR_CONTROL_SEQUENCER_ILLEGAL_TRAP_EN): sticky
//              flag set when an undefined opcode is accepted, cleared by rst.
// Scalar ops issue one beat; vector ops issue VEC_BEATS beats with beat_idx.
module vector_control_sequencer
  import vector_ctrl_pkg::*;
#(
  parameter int OPCODE_W  = 5,
  parameter int ALU_OP_W  = 5,
  parameter int WB_SEL_W  = 2,
  parameter int VEC_BEATS = 4,
  parameter int CTRL_W    = 5 + 2*WB_SEL_W + 2*ALU_OP_W
) (
  input  logic clk,
  input  logic rst,
  vector_control_sequencer_if.slave bus
`ifdef VECTOR_CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
  ,
  output logic illegal_op
`endif
);

  localparam int BIDX_W = (VEC_BEATS > 1) ? $clog2(VEC_BEATS) : 1;

  logic [OPCODE_W-1:0] opcode_raw;
  logic [OPC_W-1:0]    op_in;
  ctrl_word_t          dec_word;
  logic                dec_illegal;
  logic [CTRL_W-1:0]   dec_flat;
  logic                multi_beat;

  assign opcode_raw = bus.opcode;
  assign op_in      = OPC_W'(opcode_raw);

  opcode_decoder u_dec (
    .opcode  (op_in),
    .ctrl    (dec_word),
    .illegal (dec_illegal)
  );

  assign dec_flat = {dec_word.load, dec_word.wre, dec_word.vector_wre,
                     dec_word.wme_a, dec_word.wme_b,
                     WB_SEL_W'(dec_word.wb_sel), WB_SEL_W'(dec_word.vwb_sel),
                     ALU_OP_W'(dec_word.alu_op), ALU_OP_W'(dec_word.valu_op)};

  // Undefined codes with the vector bit set still issue as a single nop beat.
  assign multi_beat = is_vector_op(op_in) && !dec_illegal && (VEC_BEATS > 1);

  state_t            state_q, state_d;
  logic              valid_q, valid_d;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [BIDX_W-1:0] beat_q, beat_d, beat_inc;
  logic              last_q, last_d;
  logic              branch_q, branch_d;
  logic              ready, hs;

  assign ready    = !rst && (state_q == IDLE || (last_q && !bus.stall));
  assign hs       = bus.instr_valid && ready;
  assign beat_inc = beat_q + 1'b1;

  always_comb begin
    state_d  = state_q;
    valid_d  = valid_q;
    ctrl_d   = ctrl_q;
    beat_d   = beat_q;
    last_d   = last_q;
    branch_d = branch_q;
    if (bus.flush || !(state_q == BUSY && bus.stall)) begin
      if (!bus.flush && hs) begin
        state_d  = BUSY;
        valid_d  = 1'b1;
        ctrl_d   = dec_flat;
        beat_d   = '0;
        last_d   = !multi_beat;
        branch_d = (op_in == OP_BNE);
      end else if (!bus.flush && state_q == BUSY && !last_q) begin
        beat_d = beat_inc;
        last_d = (beat_inc == BIDX_W'(VEC_BEATS - 1));
      end else begin
        state_d  = IDLE;
        valid_d  = 1'b0;
        ctrl_d   = '0;
        beat_d   = '0;
        last_d   = 1'b0;
        branch_d = 1'b0;
      end
    end
  end

  // Stage boundary: registered control word to execute.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      valid_q  <= 1'b0;
      ctrl_q   <= '0;
      beat_q   <= '0;
      last_q   <= 1'b0;
      branch_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      valid_q  <= valid_d;
      ctrl_q   <= ctrl_d;
      beat_q   <= beat_d;
      last_q   <= last_d;
      branch_q <= branch_d;
    end
  end

`ifdef VECTOR_CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;

  assign illegal_d = illegal_q | (hs && !bus.flush && dec_illegal);

  always_ff @(posedge clk) begin
    if (rst) illegal_q <= 1'b0;
    else     illegal_q <= illegal_d;
  end

  assign illegal_op = illegal_q;
`endif

  assign bus.instr_ready     = ready;
  assign bus.ctrl_valid      = valid_q;
  assign bus.control_signals = ctrl_q;
  assign bus.beat_idx        = beat_q;
  assign bus.last_beat       = last_q;
  assign bus.is_branch       = branch_q;

endmodule

// File: tb/tb_vector_control_sequencer.sv
// Scoreboard bench for vector_control_sequencer: the driver pushes the expected
// beats of every accepted opcode; the monitor pops one beat per advancing cycle.
module tb_vector_control_sequencer;

  localparam int VEC_BEATS = 4;
  localparam int CTRL_W    = 19;
  localparam int BIDX_W    = 2;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vector_control_sequencer_if #(.OPCODE_W(5), .CTRL_W(CTRL_W), .BIDX_W(BIDX_W)) bus ();

`ifdef VECTOR_CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
  logic illegal_op;
  vector_control_sequencer #(.VEC_BEATS(VEC_BEATS)) dut (
    .clk(clk), .rst(rst), .bus(bus), .illegal_op(illegal_op));
`else
  vector_control_sequencer #(.VEC_BEATS(VEC_BEATS)) dut (
    .clk(clk), .rst(rst), .bus(bus));
`endif

  typedef struct {
    bit         r;
    bit         v;
    logic [4:0] op;
    bit         st;
    bit         fl;
  } stim_t;

  typedef struct {
    logic [CTRL_W-1:0] w;
    int                idx;
    bit                last;
    bit                br;
  } beat_t;

  stim_t stim_q[$];
  beat_t exp_q[$];
  int    checks   = 0;
  int    failures = 0;
  bit    ill_exp  = 0;

  function automatic bit ref_defined(input logic [4:0] op);
    return (op <= 5'd7) || (op == 5'd17) || (op == 5'd18) ||
           (op >= 5'd19 && op <= 5'd26) || (op >= 5'd28 && op <= 5'd30);
  endfunction

  // Control word built from the decode rules: {load,wre,vwre,wme_a,wme_b,wb,vwb,alu,valu}
  function automatic logic [CTRL_W-1:0] ref_word(input logic [4:0] op);
    logic ld, w, vw, wa, wb;
    logic [1:0] s, vs;
    logic [4:0] a, va;
    {ld, w, vw, wa, wb, s, vs, a, va} = '0;
    if (op <= 5'd7) begin
      a  = op;
      wa = (op == 5'd1);
      ld = (op == 5'd2);
      w  = (op == 5'd2) || (op >= 5'd4);
      s  = (op >= 5'd4) ? 2'b01 : 2'b00;
    end else if (ref_defined(op)) begin
      va = op;
      wb = (op == 5'd17);
      ld = (op == 5'd18);
      vw = (op != 5'd17);
      vs = (op >= 5'd19) ? 2'b01 : 2'b00;
    end
    return {ld, w, vw, wa, wb, s, vs, a, va};
  endfunction

  task automatic push_op(input logic [4:0] op);
    int n;
    beat_t b;
    n = (op[4] && ref_defined(op)) ? VEC_BEATS : 1;
    for (int i = 0; i < n; i++) begin
      b.w    = ref_word(op);
      b.idx  = i;
      b.last = (i == n - 1);
      b.br   = (op == 5'd3);
      exp_q.push_back(b);
    end
    if (!ref_defined(op)) ill_exp = 1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic add(input bit r, input bit v, input logic [4:0] op,
                     input bit st, input bit fl, input int n);
    stim_t s;
    s.r = r; s.v = v; s.op = op; s.st = st; s.fl = fl;
    for (int i = 0; i < n; i++) stim_q.push_back(s);
  endtask

  // Driver
  initial begin
    bit         hs;
    logic [4:0] hs_op;
    hs = 0;
    hs_op = '0;
    bus.instr_valid = 0;
    bus.opcode = '0;
    bus.stall = 0;
    bus.flush = 0;

    add(1, 0, 5'd0, 0, 0, 3);
    add(0, 1, 5'b00101, 0, 0, 1);  add(0, 0, 0, 0, 0, 2);      // single add
    add(0, 1, 5'b10101, 0, 0, 1);  add(0, 0, 0, 0, 0, 5);      // MixColumns burst
    add(0, 1, 5'b10111, 0, 0, 1);  add(0, 0, 0, 0, 0, 1);      // stall on beat 1
    add(0, 0, 0, 1, 0, 3);         add(0, 0, 0, 0, 0, 5);
    add(0, 1, 5'b00010, 0, 0, 1);  add(0, 1, 5'b10001, 0, 0, 1); // ldr then vstr
    add(0, 0, 0, 0, 0, 5);
    add(0, 1, 5'b10110, 0, 0, 1);  add(0, 0, 0, 0, 0, 2);      // flush+stall on beat 2
    add(0, 1, 5'b00101, 1, 1, 1);  add(0, 0, 0, 0, 0, 2);
    add(0, 1, 5'b10101, 0, 0, 1);  add(0, 0, 0, 0, 0, 3);      // vector back-to-back
    add(0, 1, 5'b10100, 0, 0, 1);  add(0, 0, 0, 0, 0, 5);
    add(0, 1, 5'b00011, 0, 0, 1);  add(0, 0, 0, 0, 0, 1);      // bne
    add(0, 1, 5'b01000, 0, 0, 1);  add(0, 0, 0, 0, 0, 3);      // undefined opcode
    add(0, 1, 5'b11110, 0, 0, 1);  add(0, 0, 0, 0, 0, 1);      // reset mid-burst
    add(1, 0, 0, 0, 0, 1);         add(0, 0, 0, 0, 0, 2);
    for (int i = 0; i < 3000; i++)
      add($urandom_range(0, 199) == 0, $urandom_range(0, 9) < 6, 5'($urandom),
          $urandom_range(0, 4) == 0, $urandom_range(0, 29) == 0, 1);
    add(0, 0, 0, 0, 0, 8);

    while (stim_q.size() != 0) begin
      stim_t s;
      s = stim_q.pop_front();
      @(posedge clk);
      if (hs) push_op(hs_op);
      #1;
      rst = s.r;
      bus.instr_valid = s.v;
      bus.opcode = s.op;
      bus.stall = s.st;
      bus.flush = s.fl;
      @(negedge clk);
      hs = s.v && bus.instr_ready && !s.fl && !s.r;
      hs_op = s.op;
    end
    @(posedge clk);
    @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Monitor
  initial begin
    @(posedge clk);
    forever begin
      beat_t b;
      @(negedge clk);
      if (exp_q.size() == 0) begin
        chk("ctrl_valid_idle", 32'(bus.ctrl_valid), 32'd0);
        chk("ctrl_word_idle", 32'(bus.control_signals), 32'd0);
      end else begin
        b = exp_q[0];
        chk("ctrl_valid", 32'(bus.ctrl_valid), 32'd1);
        chk("ctrl_word", 32'(bus.control_signals), 32'(b.w));
        chk("beat_idx", 32'(bus.beat_idx), 32'(b.idx));
        chk("last_beat", 32'(bus.last_beat), 32'(b.last));
        chk("is_branch", 32'(bus.is_branch), 32'(b.br));
      end
      chk("instr_ready", 32'(bus.instr_ready),
          32'(!rst && (exp_q.size() == 0 || (exp_q.size() == 1 && !bus.stall))));
`ifdef VECTOR_CONTROL_SEQUENCER_ILLEGAL_TRAP_EN
      chk("illegal_op", 32'(illegal_op), 32'(ill_exp));
`endif
      if (rst || bus.flush) begin
        exp_q.delete();
        if (rst) ill_exp = 0;
      end else if (exp_q.size() != 0 && !bus.stall) begin
        void'(exp_q.pop_front());
      end
    end
  end

endmodule
